// File: rtl/memory_access.sv
// memory_access -- SPARC memory stage between Execute and Writeback.
//
// Accepts one instruction per cycle while idle (mem_ready high), issues
// doubleword-aligned data-cache requests for loads and stores, and passes every
// other op through to Writeback one cycle later. Stores are posted: Writeback
// sees them as soon as the cache accepts the request.
//
// Ports
//   clk, reset               clock (rising edge), asynchronous active-low reset
//   MEM_*_in                 instruction fields from Execute
//   mem_ready                combinational, high only in IDLE
//   dc_req_*                 registered cache request, held until dc_req_ready
//   dc_resp_valid/data       load doubleword, honoured only while waiting for it
//   WB_*                     registered one-cycle result pulse to Writeback
//
// Build option
//   MEM_ALIGN_CHECK_EN  when defined, misaligned half/word/double accesses
//                       raise WB_trap and issue no cache request; otherwise
//                       the low address bits are ignored and WB_trap is 0.
module memory_access #(
   parameter int ADDR_WIDTH     = 32,
   parameter int BUS_DATA_WIDTH = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [ADDR_WIDTH-1:0]       MEM_alures_in,
   input  logic [BUS_DATA_WIDTH-1:0]   MEM_valD_in,
   input  logic [1:0]                  MEM_op_in,
   input  logic [5:0]                  MEM_op3_in,
   input  logic [4:0]                  MEM_rd_in,
   input  logic                        MEM_regWrite_in,
   input  logic                        MEM_regWriteDouble_in,
   output logic                        mem_ready,
   output logic                        dc_req_valid,
   input  logic                        dc_req_ready,
   output logic [ADDR_WIDTH-1:0]       dc_req_addr,
   output logic                        dc_req_we,
   output logic [BUS_DATA_WIDTH/8-1:0] dc_req_be,
   output logic [BUS_DATA_WIDTH-1:0]   dc_req_wdata,
   input  logic                        dc_resp_valid,
   input  logic [BUS_DATA_WIDTH-1:0]   dc_resp_data,
   output logic                        WB_valid,
   output logic [4:0]                  WB_rd,
   output logic [BUS_DATA_WIDTH-1:0]   WB_data,
   output logic                        WB_regWrite,
   output logic                        WB_regWriteDouble,
   output logic                        WB_trap
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t r_state, w_next;

   logic                        r_req_valid, r_req_we;
   logic [ADDR_WIDTH-1:0]       r_req_addr;
   logic [BUS_DATA_WIDTH/8-1:0] r_req_be;
   logic [BUS_DATA_WIDTH-1:0]   r_req_wdata;
   logic [1:0]                  r_ld_size;
   logic                        r_ld_sign;
   logic [2:0]                  r_ld_off;
   logic [4:0]                  r_rd;
   logic                        r_rw, r_rwd;
   logic                        r_wb_valid, r_wb_rw, r_wb_rwd, r_wb_trap;
   logic [4:0]                  r_wb_rd;
   logic [BUS_DATA_WIDTH-1:0]   r_wb_data;

   // op3[1:0]: 00 word, 01 byte, 10 half, 11 double; op3[2] store; op3[3] signed
   logic                        w_is_mem, w_trap, w_issue;
   logic [1:0]                  w_size;
   logic [2:0]                  w_off, w_aoff;
   logic [BUS_DATA_WIDTH/8-1:0] w_be;
   logic [BUS_DATA_WIDTH-1:0]   w_wdata, w_sh, w_ld_data;

   assign w_is_mem = (MEM_op_in == 2'b11) && (MEM_op3_in[5:4] == 2'b00) &&
                     (!MEM_op3_in[3] || MEM_op3_in[2:0] == 3'b001 || MEM_op3_in[2:0] == 3'b010);
   assign w_size   = MEM_op3_in[1:0];
   assign w_off    = MEM_alures_in[2:0];

   // Offset rounded down to the access size; differs from w_off only when misaligned.
   always_comb begin
      w_aoff  = 3'b000;
      w_be    = 8'hFF;
      w_wdata = MEM_valD_in;
      case (w_size)
         2'b01: begin
            w_aoff  = w_off;
            w_be    = 8'h80 >> w_aoff;
            w_wdata = {8{MEM_valD_in[7:0]}};
         end
         2'b10: begin
            w_aoff  = {w_off[2:1], 1'b0};
            w_be    = 8'hC0 >> w_aoff;
            w_wdata = {4{MEM_valD_in[15:0]}};
         end
         2'b00: begin
            w_aoff  = {w_off[2], 2'b00};
            w_be    = 8'hF0 >> w_aoff;
            w_wdata = {2{MEM_valD_in[31:0]}};
         end
         default: ;
      endcase
   end

`ifdef MEM_ALIGN_CHECK_EN
   assign w_trap = w_is_mem && (w_aoff != w_off);
`else
   assign w_trap = 1'b0;
`endif
   assign w_issue = w_is_mem && !w_trap;

   // Big-endian lanes: shifting the addressed lane to the top makes the
   // extracted field always start at bit 63.
   assign w_sh = dc_resp_data << {r_ld_off, 3'b000};
   always_comb begin
      w_ld_data = '0;
      case (r_ld_size)
         2'b01:   w_ld_data[31:0] = {{24{r_ld_sign & w_sh[63]}}, w_sh[63:56]};
         2'b10:   w_ld_data[31:0] = {{16{r_ld_sign & w_sh[63]}}, w_sh[63:48]};
         2'b00:   w_ld_data[31:0] = w_sh[63:32];
         default: w_ld_data       = dc_resp_data;
      endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_issue) w_next = REQ;
         REQ:     if (dc_req_ready) w_next = r_req_we ? IDLE : WAIT;
         WAIT:    if (dc_resp_valid) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_req_valid <= 1'b0;  r_req_we  <= 1'b0;  r_req_addr <= '0;
         r_req_be    <= '0;    r_req_wdata <= '0;
         r_ld_size   <= 2'b00; r_ld_sign <= 1'b0;  r_ld_off   <= 3'b000;
         r_rd        <= '0;    r_rw      <= 1'b0;  r_rwd      <= 1'b0;
         r_wb_valid  <= 1'b0;  r_wb_rd   <= '0;    r_wb_data  <= '0;
         r_wb_rw     <= 1'b0;  r_wb_rwd  <= 1'b0;  r_wb_trap  <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         r_wb_trap  <= 1'b0;
         case (r_state)
            IDLE: begin
               r_rd      <= MEM_rd_in;
               r_rw      <= MEM_regWrite_in;
               r_rwd     <= MEM_regWriteDouble_in;
               r_ld_size <= w_size;
               r_ld_sign <= MEM_op3_in[3];
               r_ld_off  <= w_aoff;
               if (w_issue) begin
                  r_req_valid <= 1'b1;
                  r_req_addr  <= {MEM_alures_in[ADDR_WIDTH-1:3], 3'b000};
                  r_req_we    <= MEM_op3_in[2];
                  r_req_be    <= w_be;
                  r_req_wdata <= w_wdata;
               end else begin
                  r_wb_valid <= 1'b1;
                  r_wb_rd    <= MEM_rd_in;
                  r_wb_data  <= w_trap ? '0 :
                                {{(BUS_DATA_WIDTH-ADDR_WIDTH){1'b0}}, MEM_alures_in};
                  r_wb_rw    <= MEM_regWrite_in & !w_trap;
                  r_wb_rwd   <= MEM_regWriteDouble_in & !w_trap;
                  r_wb_trap  <= w_trap;
               end
            end
            REQ: if (dc_req_ready) begin
               r_req_valid <= 1'b0;
               if (r_req_we) begin
                  r_wb_valid <= 1'b1;
                  r_wb_rd    <= r_rd;
                  r_wb_data  <= '0;
                  r_wb_rw    <= 1'b0;
                  r_wb_rwd   <= 1'b0;
               end
            end
            WAIT: if (dc_resp_valid) begin
               r_wb_valid <= 1'b1;
               r_wb_rd    <= r_rd;
               r_wb_data  <= w_ld_data;
               r_wb_rw    <= r_rw;
               r_wb_rwd   <= r_rwd;
            end
            default: ;
         endcase
      end
   end

   assign mem_ready         = (r_state == IDLE);
   assign dc_req_valid      = r_req_valid;
   assign dc_req_addr       = r_req_addr;
   assign dc_req_we         = r_req_we;
   assign dc_req_be         = r_req_be;
   assign dc_req_wdata      = r_req_wdata;
   assign WB_valid          = r_wb_valid;
   assign WB_rd             = r_wb_rd;
   assign WB_data           = r_wb_data;
   assign WB_regWrite       = r_wb_rw;
   assign WB_regWriteDouble = r_wb_rwd;
   assign WB_trap           = r_wb_trap;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: the stimulus process pushes the expected
// Writeback result whenever it presents an instruction that will be captured;
// the monitor pops and compares on every WB_valid.
module tb_memory_access;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] alures = '0;
   logic [63:0] vald = '0;
   logic [1:0]  op = '0;
   logic [5:0]  op3 = '0;
   logic [4:0]  rd = '0;
   logic        rw = 1'b0, rwd = 1'b0;
   logic        mem_ready, dc_req_valid, dreq_rdy = 1'b0, dc_req_we, dresp_v = 1'b0;
   logic [31:0] dc_req_addr;
   logic [7:0]  dc_req_be;
   logic [63:0] dc_req_wdata, dresp_d = '0, WB_data;
   logic        WB_valid, WB_regWrite, WB_regWriteDouble, WB_trap;
   logic [4:0]  WB_rd;

   memory_access dut (
      .clk(clk), .reset(rst_n),
      .MEM_alures_in(alures), .MEM_valD_in(vald), .MEM_op_in(op), .MEM_op3_in(op3),
      .MEM_rd_in(rd), .MEM_regWrite_in(rw), .MEM_regWriteDouble_in(rwd),
      .mem_ready(mem_ready),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dreq_rdy), .dc_req_addr(dc_req_addr),
      .dc_req_we(dc_req_we), .dc_req_be(dc_req_be), .dc_req_wdata(dc_req_wdata),
      .dc_resp_valid(dresp_v), .dc_resp_data(dresp_d),
      .WB_valid(WB_valid), .WB_rd(WB_rd), .WB_data(WB_data), .WB_regWrite(WB_regWrite),
      .WB_regWriteDouble(WB_regWriteDouble), .WB_trap(WB_trap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
      logic        rw, rwd, trap;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [4:0] r, input logic [63:0] d,
                           input logic w, input logic wd, input logic t);
      exp_t e;
      e.rd = r; e.data = d; e.rw = w; e.rwd = wd; e.trap = t;
      sb.push_back(e);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (WB_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wb_unexpected: got WB_valid=1 rd=%0d data=%0h, expected no result",
                     WB_rd, WB_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_rd", 64'(WB_rd), 64'(e.rd));
            chk("wb_data", WB_data, e.data);
            chk("wb_regWrite", 64'(WB_regWrite), 64'(e.rw));
            chk("wb_regWriteDouble", 64'(WB_regWriteDouble), 64'(e.rwd));
            chk("wb_trap", 64'(WB_trap), 64'(e.trap));
         end
      end
   end

   task automatic apply(input logic [1:0] o, input logic [5:0] o3, input logic [31:0] a,
                        input logic [63:0] v, input logic [4:0] r, input logic w, input logic wd);
      op = o; op3 = o3; alures = a; vald = v; rd = r; rw = w; rwd = wd;
   endtask

   // Called at a falling edge: present a NOP; it is captured if the stage is idle.
   task automatic nop_step();
      apply(2'b00, 6'h00, 32'h0, 64'h0, 5'd0, 1'b0, 1'b0);
      if (mem_ready === 1'b1 && rst_n) push_exp(5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pass_op(input logic [1:0] o, input logic [5:0] o3, input logic [31:0] a,
                          input logic [4:0] r, input logic w, input logic wd);
      @(negedge clk);
      apply(o, o3, a, 64'h0, r, w, wd);
      chk("pt_ready", 64'(mem_ready), 64'd1);
      push_exp(r, {32'h0, a}, w, wd, 1'b0);
      @(negedge clk); nop_step();
      chk("pt_ready_stays", 64'(mem_ready), 64'd1);
   endtask

   task automatic mem_op(input logic [5:0] o3, input logic [31:0] a, input logic [63:0] v,
                         input logic [4:0] r, input logic w, input logic wd, input int dly,
                         input logic [63:0] resp, input logic [31:0] e_addr,
                         input logic [7:0] e_be, input logic [63:0] e_wdata,
                         input logic [63:0] e_data, input logic e_trap);
      logic st;
      st = o3[2];
      @(negedge clk);
      apply(2'b11, o3, a, v, r, w, wd);
      chk("mem_ready_pre", 64'(mem_ready), 64'd1);
      if (e_trap)  push_exp(r, 64'h0, 1'b0, 1'b0, 1'b1);
      else if (st) push_exp(r, 64'h0, 1'b0, 1'b0, 1'b0);
      else         push_exp(r, e_data, w, wd, 1'b0);
      @(negedge clk); nop_step();
      if (e_trap) begin
         chk("trap_no_req", 64'(dc_req_valid), 64'd0);
         chk("trap_ready", 64'(mem_ready), 64'd1);
         return;
      end
      for (int c = 0; c <= dly; c++) begin
         chk("req_valid", 64'(dc_req_valid), 64'd1);
         chk("req_addr", 64'(dc_req_addr), 64'(e_addr));
         chk("req_be", 64'(dc_req_be), 64'(e_be));
         chk("req_we", 64'(dc_req_we), 64'(st));
         if (st) chk("req_wdata", dc_req_wdata, e_wdata);
         chk("busy_not_ready", 64'(mem_ready), 64'd0);
         dreq_rdy = (c == dly);
         @(negedge clk); nop_step();
      end
      dreq_rdy = 1'b0;
      if (!st) begin
         chk("wait_req_dropped", 64'(dc_req_valid), 64'd0);
         chk("wait_not_ready", 64'(mem_ready), 64'd0);
         dresp_v = 1'b1; dresp_d = resp;
         @(negedge clk); dresp_v = 1'b0; dresp_d = '0; nop_step();
      end
      chk("done_ready", 64'(mem_ready), 64'd1);
   endtask

   initial begin
      #1;
      chk("rst_ready", 64'(mem_ready), 64'd1);
      chk("rst_req_valid", 64'(dc_req_valid), 64'd0);
      chk("rst_wb_valid", 64'(WB_valid), 64'd0);
      chk("rst_wb_data", WB_data, 64'h0);
      chk("rst_req_be", 64'(dc_req_be), 64'd0);
      @(negedge clk); rst_n = 1'b1; nop_step();

      pass_op(2'b10, 6'h00, 32'h1234, 5'd3, 1'b1, 1'b0);
      pass_op(2'b01, 6'h00, 32'hCAFE_F00D, 5'd31, 1'b1, 1'b1);
      pass_op(2'b11, 6'b001000, 32'h55, 5'd9, 1'b1, 1'b0);

      // op3   addr          valD                    rd  rw  rwd dly resp                    addr          be     wdata                   data                    trap
      mem_op(6'b001001, 32'h1005, 64'h0, 5'd4, 1, 0, 0, 64'h0011_2233_4485_6677, 32'h1000, 8'h04, 64'h0, 64'h0000_0000_FFFF_FF85, 0);
      mem_op(6'b000110, 32'h2002, 64'hBEEF, 5'd5, 1, 0, 3, 64'h0, 32'h2000, 8'h30, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0, 0);
      mem_op(6'b000011, 32'h3008, 64'h0, 5'd6, 1, 1, 0, 64'hAAAA_BBBB_CCCC_DDDD, 32'h3008, 8'hFF, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 0);
`ifdef MEM_ALIGN_CHECK_EN
      mem_op(6'b000000, 32'h4002, 64'h0, 5'd8, 1, 0, 0, 64'h0, 32'h0, 8'h00, 64'h0, 64'h0, 1);
`else
      mem_op(6'b000000, 32'h4002, 64'h0, 5'd8, 1, 0, 0, 64'h1122_3344_5566_7788, 32'h4000, 8'hF0, 64'h0, 64'h0000_0000_1122_3344, 0);
`endif
      mem_op(6'b000000, 32'h4004, 64'h0, 5'd13, 1, 0, 1, 64'h1122_3344_5566_7788, 32'h4000, 8'h0F, 64'h0, 64'h0000_0000_5566_7788, 0);
      mem_op(6'b000001, 32'h1007, 64'h0, 5'd10, 1, 0, 0, 64'h0123_4567_89AB_CDFE, 32'h1000, 8'h01, 64'h0, 64'h0000_0000_0000_00FE, 0);
      mem_op(6'b000010, 32'h100E, 64'h0, 5'd11, 1, 0, 0, 64'h0123_4567_89AB_CDFE, 32'h1008, 8'h03, 64'h0, 64'h0000_0000_0000_CDFE, 0);
      mem_op(6'b001010, 32'h1004, 64'h0, 5'd12, 1, 0, 0, 64'h0123_4567_89AB_CDFE, 32'h1000, 8'h0C, 64'h0, 64'h0000_0000_FFFF_89AB, 0);
      mem_op(6'b000101, 32'h2003, 64'h1234_5678_9ABC_DE5A, 5'd14, 1, 0, 1, 64'h0, 32'h2000, 8'h10, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0, 0);
      mem_op(6'b000100, 32'h2004, 64'hDEAD_BEEF, 5'd15, 1, 0, 0, 64'h0, 32'h2000, 8'h0F, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 0);
      mem_op(6'b000111, 32'h2008, 64'h0102_0304_0506_0708, 5'd16, 1, 1, 0, 64'h0, 32'h2008, 8'hFF, 64'h0102_0304_0506_0708, 64'h0, 0);

      // Reset while waiting for load data; the killed load has no expected result.
      @(negedge clk); apply(2'b11, 6'b000000, 32'h5000, 64'h0, 5'd7, 1'b1, 1'b0);
      @(negedge clk); nop_step(); dreq_rdy = 1'b1;
      @(negedge clk); nop_step(); dreq_rdy = 1'b0;
      chk("pre_rst_in_wait", 64'(mem_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("midwait_rst_ready", 64'(mem_ready), 64'd1);
      chk("midwait_rst_req_valid", 64'(dc_req_valid), 64'd0);
      chk("midwait_rst_wb_valid", 64'(WB_valid), 64'd0);
      chk("midwait_rst_req_addr", 64'(dc_req_addr), 64'd0);
      dresp_v = 1'b1; dresp_d = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      chk("rst_stray_resp_wb", 64'(WB_valid), 64'd0);
      dresp_v = 1'b0;
      rst_n = 1'b1; nop_step();
      @(negedge clk); dresp_v = 1'b1; nop_step();
      @(negedge clk); dresp_v = 1'b0; dresp_d = '0; nop_step();
      chk("post_rst_idle", 64'(dc_req_valid), 64'd0);
      @(negedge clk); dreq_rdy = 1'b1; nop_step();
      @(negedge clk); dreq_rdy = 1'b0; nop_step();
      chk("stray_ready_no_req", 64'(dc_req_valid), 64'd0);

      // Drain: stop captures and check every expected result appeared.
      @(negedge clk); #1 rst_n = 1'b0;
      @(negedge clk); #1;
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
